// File: rtl/amba_pkg.sv
// Shared AMBA definitions for the AXI4-Lite to APB bridge: response codes
// and the bridge sequencing states.
package amba_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/axi_wr_capture.sv
// AW/W holding registers. Each channel is accepted independently and the pair
// is presented as one write once both halves are available (held or firing now).
module axi_wr_capture (
  input  logic        clock,
  input  logic        reset,
  input  logic        accept_en,
  input  logic        consume,
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [31:0] in_awaddr,
  input  logic        in_wvalid,
  output logic        in_wready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  output logic        wr_avail,
  output logic        half_held,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);

  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic        aw_fire, w_fire;

  assign in_awready = accept_en && !aw_held_q;
  assign in_wready  = accept_en && !w_held_q;
  assign aw_fire    = in_awvalid && in_awready;
  assign w_fire     = in_wvalid && in_wready;

  // A half arriving this cycle bypasses its register so the grant is not delayed.
  assign wr_avail  = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign half_held = aw_held_q || w_held_q;
  assign wr_addr   = aw_held_q ? addr_q : in_awaddr;
  assign wr_data   = w_held_q ? data_q : in_wdata;
  assign wr_strb   = w_held_q ? strb_q : in_wstrb;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (aw_fire) begin
      aw_held_d = 1'b1;
      addr_d    = in_awaddr;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      data_d   = in_wdata;
      strb_d   = in_wstrb;
    end
    if (consume) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: rtl/axi4lite_apb_bridge.sv
// AXI4-Lite slave to APB master bridge: one transaction in flight, round-robin
// read/write arbitration and an optional ACCESS-phase timeout reported as SLVERR.
module axi4lite_apb_bridge
  import amba_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0,
  parameter logic [2:0]  PPROT   = 3'b000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [31:0] in_awaddr,
  input  logic        in_wvalid,
  output logic        in_wready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  output logic        in_bvalid,
  input  logic        in_bready,
  output logic [1:0]  in_bresp,
  input  logic        in_arvalid,
  output logic        in_arready,
  input  logic [31:0] in_araddr,
  output logic        in_rvalid,
  input  logic        in_rready,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic [31:0] out_paddr,
  output logic        out_psel,
  output logic        out_penable,
  output logic [2:0]  out_pprot,
  output logic        out_pwrite,
  output logic [31:0] out_pwdata,
  output logic [3:0]  out_pstrb,
  input  logic        out_pready,
  input  logic [31:0] out_prdata,
  input  logic        out_pslverr
);

  bridge_state_e state_q, state_d;
  logic          run_q;
  logic          last_wr_q, last_wr_d;
  logic          is_write_q, is_write_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic [1:0]    resp_q, resp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   cnt_q, cnt_d;

  logic          idle, apb_active, grant_wr, grant_rd;
  logic          wr_avail, half_held;
  logic [31:0]   wr_addr, wr_data;
  logic [3:0]    wr_strb;

  // run_q keeps every ready low while reset is asserted and for its release cycle.
  assign idle       = (state_q == IDLE) && run_q;
  assign apb_active = (state_q == SETUP) || (state_q == ACCESS);

  axi_wr_capture u_wr_capture (
    .clock      (clock),
    .reset      (reset),
    .accept_en  (idle),
    .consume    (grant_wr),
    .in_awvalid (in_awvalid),
    .in_awready (in_awready),
    .in_awaddr  (in_awaddr),
    .in_wvalid  (in_wvalid),
    .in_wready  (in_wready),
    .in_wdata   (in_wdata),
    .in_wstrb   (in_wstrb),
    .wr_avail   (wr_avail),
    .half_held  (half_held),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb)
  );

  // A read loses only when a write is ready and the previous grant was a read.
  assign in_arready = idle && !half_held && !(wr_avail && !last_wr_q);
  assign grant_rd   = in_arvalid && in_arready;
  assign grant_wr   = idle && wr_avail && !grant_rd;

  always_comb begin
    state_d    = state_q;
    last_wr_d  = last_wr_q;
    is_write_d = is_write_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    resp_d     = resp_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d    = SETUP;
          last_wr_d  = 1'b1;
          is_write_d = 1'b1;
          paddr_d    = wr_addr;
          pwdata_d   = wr_data;
          pstrb_d    = wr_strb;
        end else if (grant_rd) begin
          state_d    = SETUP;
          last_wr_d  = 1'b0;
          is_write_d = 1'b0;
          paddr_d    = in_araddr;
          pwdata_d   = '0;
          pstrb_d    = '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        if (out_pready) begin
          state_d = RESP;
          resp_d  = out_pslverr ? RESP_SLVERR : RESP_OKAY;
          rdata_d = (!is_write_q && !out_pslverr) ? out_prdata : 32'd0;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
          state_d = RESP;
          resp_d  = RESP_SLVERR;
          rdata_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        if (is_write_q ? in_bready : in_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      last_wr_q  <= 1'b0;
      is_write_q <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      last_wr_q  <= last_wr_d;
      is_write_q <= is_write_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_psel    = apb_active;
  assign out_penable = (state_q == ACCESS);
  assign out_pprot   = PPROT;
  assign out_pwrite  = apb_active && is_write_q;
  assign out_paddr   = apb_active ? paddr_q : 32'd0;
  assign out_pwdata  = apb_active ? pwdata_q : 32'd0;
  assign out_pstrb   = apb_active ? pstrb_q : 4'd0;
  assign in_bvalid   = (state_q == RESP) && is_write_q;
  assign in_rvalid   = (state_q == RESP) && !is_write_q;
  assign in_bresp    = in_bvalid ? resp_q : RESP_OKAY;
  assign in_rresp    = in_rvalid ? resp_q : RESP_OKAY;
  assign in_rdata    = in_rvalid ? rdata_q : 32'd0;

endmodule

// File: tb/tb_axi4lite_apb_bridge.sv
// Directed and randomized bench for axi4lite_apb_bridge; each transaction's
// expected APB fields and AXI response are derived from the AXI/APB rules.
module tb_axi4lite_apb_bridge;

  localparam int unsigned TO = 8;
  localparam logic [2:0]  PP = 3'b101;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_awvalid = 1'b0, in_awready;
  logic [31:0] in_awaddr = '0;
  logic        in_wvalid = 1'b0, in_wready;
  logic [31:0] in_wdata = '0;
  logic [3:0]  in_wstrb = '0;
  logic        in_bvalid, in_bready = 1'b0;
  logic [1:0]  in_bresp;
  logic        in_arvalid = 1'b0, in_arready;
  logic [31:0] in_araddr = '0;
  logic        in_rvalid, in_rready = 1'b0;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic [31:0] out_paddr;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = '0;
  logic        out_pslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4lite_apb_bridge #(.TIMEOUT(TO), .PPROT(PP)) dut (
    .clock(clock), .reset(reset),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
    .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
    .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
    .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs;
    in_awvalid = 1'b0; in_wvalid = 1'b0; in_arvalid = 1'b0;
    in_bready = 1'b0; in_rready = 1'b0;
    out_pready = 1'b0; out_pslverr = 1'b0; out_prdata = '0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    quiet_inputs();
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
  endtask

  // Drives AW and W (W optionally delayed) until both handshakes complete;
  // returns in the cycle after the final handshake.
  task automatic issue_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int wdelay);
    bit aw_pend = 1'b1, w_pend = 1'b1, fa, fw;
    for (int i = 0; i < 30; i++) begin
      in_awaddr  = addr;
      in_wdata   = data;
      in_wstrb   = strb;
      in_awvalid = aw_pend;
      in_wvalid  = w_pend && (i >= wdelay);
      #1;
      fa = in_awvalid && in_awready;
      fw = in_wvalid && in_wready;
      tick();
      if (fa) aw_pend = 1'b0;
      if (fw) w_pend = 1'b0;
      if (!aw_pend && !w_pend) break;
    end
    in_awvalid = 1'b0;
    in_wvalid  = 1'b0;
    chk("wr_issue_done", 32'(!aw_pend && !w_pend), 32'd1);
  endtask

  task automatic issue_read(input logic [31:0] addr);
    bit fired = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_araddr  = addr;
      in_arvalid = 1'b1;
      #1;
      fired = in_arready;
      tick();
      if (fired) break;
    end
    in_arvalid = 1'b0;
    chk("rd_issue_done", 32'(fired), 32'd1);
  endtask

  // Entered in the SETUP cycle. Plays the APB slave for waits+1 ACCESS cycles,
  // then checks the AXI response against the expected outcome.
  task automatic serve(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int waits, input bit err,
                       input logic [31:0] prd, input int rhold);
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    exp_resp  = err ? 2'b10 : 2'b00;
    exp_rdata = (wr || err) ? 32'd0 : prd;
    chk("setup_psel", 32'(out_psel), 32'd1);
    chk("setup_penable", 32'(out_penable), 32'd0);
    chk("setup_pwrite", 32'(out_pwrite), 32'(wr));
    chk("setup_paddr", out_paddr, addr);
    chk("setup_pwdata", out_pwdata, wr ? data : 32'd0);
    chk("setup_pstrb", 32'(out_pstrb), wr ? 32'(strb) : 32'd0);
    chk("setup_pprot", 32'(out_pprot), 32'(PP));
    tick();
    for (int k = 0; k <= waits; k++) begin
      chk("access_psel_penable", 32'({out_psel, out_penable}), 32'd3);
      chk("access_paddr", out_paddr, addr);
      chk("access_pwdata", out_pwdata, wr ? data : 32'd0);
      out_pready  = (k == waits);
      out_pslverr = err && (k == waits);
      out_prdata  = (k == waits) ? prd : $urandom;
      tick();
    end
    out_pready  = 1'b0;
    out_pslverr = 1'b0;
    out_prdata  = $urandom;
    chk("resp_psel_low", 32'({out_psel, out_penable}), 32'd0);
    chk("resp_paddr_zero", out_paddr, 32'd0);
    if (wr) begin
      chk("bvalid", 32'({in_bvalid, in_rvalid}), 32'd2);
      chk("bresp", 32'(in_bresp), 32'(exp_resp));
    end else begin
      chk("rvalid", 32'({in_rvalid, in_bvalid}), 32'd2);
      chk("rresp", 32'(in_rresp), 32'(exp_resp));
      chk("rdata", in_rdata, exp_rdata);
    end
    for (int h = 0; h < rhold; h++) begin
      tick();
      chk("hold_valid", 32'(wr ? in_bvalid : in_rvalid), 32'd1);
      chk("hold_resp", 32'(wr ? in_bresp : in_rresp), 32'(exp_resp));
      if (!wr) chk("hold_rdata", in_rdata, exp_rdata);
      chk("hold_no_ar", 32'(in_arready), 32'd0);
    end
    if (wr) in_bready = 1'b1; else in_rready = 1'b1;
    tick();
    in_bready = 1'b0;
    in_rready = 1'b0;
    chk("resp_done", 32'({in_bvalid, in_rvalid}), 32'd0);
  endtask

  initial begin
    int n_acc;
    logic [31:0] a, d, p;
    logic [3:0]  s;
    bit wr, er;

    // Reset state, sampled while reset is held low.
    #2;
    chk("rst_outputs", 32'({out_psel, out_penable, out_pwrite, in_bvalid, in_rvalid,
                            in_awready, in_wready, in_arready}), 32'd0);
    chk("rst_pprot", 32'(out_pprot), 32'(PP));
    chk("rst_paddr", out_paddr, 32'd0);
    do_reset();

    // 1: AW at cycle 0, W at cycle 2, pready on first ACCESS.
    in_awaddr = 32'h1000_0004; in_awvalid = 1'b1;
    tick();
    in_awvalid = 1'b0;
    chk("t1_aw_held", 32'(in_awready), 32'd0);
    tick();
    in_wdata = 32'hDEAD_BEEF; in_wstrb = 4'hF; in_wvalid = 1'b1;
    #1;
    chk("t1_cycle2_psel", 32'(out_psel), 32'd0);
    tick();
    in_wvalid = 1'b0;
    serve(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'd0, 0);

    // 2: read with three wait states.
    issue_read(32'h1000_0000);
    serve(1'b0, 32'h1000_0000, 32'd0, 4'h0, 3, 1'b0, 32'h1234_5678, 0);

    // 3: simultaneous write and read after reset; write first, then read.
    do_reset();
    in_awaddr = 32'h0000_0040; in_wdata = 32'hA0A0_0001; in_wstrb = 4'h3;
    in_araddr = 32'h0000_0080;
    in_awvalid = 1'b1; in_wvalid = 1'b1; in_arvalid = 1'b1;
    #1;
    chk("t3_ar_loses", 32'(in_arready), 32'd0);
    tick();
    in_awvalid = 1'b0; in_wvalid = 1'b0;
    serve(1'b1, 32'h0000_0040, 32'hA0A0_0001, 4'h3, 0, 1'b0, 32'd0, 0);
    issue_read(32'h0000_0080);
    serve(1'b0, 32'h0000_0080, 32'd0, 4'h0, 0, 1'b0, 32'hCAFE_0080, 0);
    issue_write(32'h0000_00C0, 32'h1111_2222, 4'hF, 0);
    serve(1'b1, 32'h0000_00C0, 32'h1111_2222, 4'hF, 0, 1'b0, 32'd0, 0);
    // Last grant was a write, so the read wins this time.
    in_awaddr = 32'h0000_0100; in_wdata = 32'h3333_4444; in_wstrb = 4'hC;
    in_araddr = 32'h0000_0200;
    in_awvalid = 1'b1; in_wvalid = 1'b1; in_arvalid = 1'b1;
    #1;
    chk("t3b_ar_wins", 32'(in_arready), 32'd1);
    tick();
    in_awvalid = 1'b0; in_wvalid = 1'b0; in_arvalid = 1'b0;
    serve(1'b0, 32'h0000_0200, 32'd0, 4'h0, 1, 1'b0, 32'h5555_6666, 0);
    chk("t3b_write_pending", 32'(in_awready), 32'd0);
    tick();
    serve(1'b1, 32'h0000_0100, 32'h3333_4444, 4'hC, 0, 1'b0, 32'd0, 0);

    // 4: slave error on a write and on a read.
    issue_write(32'h2000_0000, 32'h0BAD_0BAD, 4'h1, 1);
    serve(1'b1, 32'h2000_0000, 32'h0BAD_0BAD, 4'h1, 0, 1'b1, 32'd0, 0);
    issue_read(32'h2000_0004);
    serve(1'b0, 32'h2000_0004, 32'd0, 4'h0, 2, 1'b1, 32'hFFFF_FFFF, 0);

    // 5: pready never arrives; exactly TO ACCESS cycles then SLVERR.
    issue_read(32'h3000_0000);
    chk("t5_setup", 32'({out_psel, out_penable}), 32'd2);
    tick();
    n_acc = 0;
    out_prdata = 32'h7777_7777;
    for (int i = 0; i < 20; i++) begin
      if (!(out_psel && out_penable)) break;
      n_acc++;
      tick();
    end
    chk("t5_access_cycles", 32'(n_acc), 32'(TO));
    chk("t5_psel_dropped", 32'(out_psel), 32'd0);
    chk("t5_rvalid", 32'(in_rvalid), 32'd1);
    chk("t5_rresp", 32'(in_rresp), 32'd2);
    chk("t5_rdata", in_rdata, 32'd0);
    in_rready = 1'b1; tick(); in_rready = 1'b0;
    // pready on the very cycle the timeout would fire: pready wins.
    issue_read(32'h3000_0010);
    serve(1'b0, 32'h3000_0010, 32'd0, 4'h0, TO - 1, 1'b0, 32'h0F0F_1234, 0);

    // 6: response backpressure, then reset mid-ACCESS.
    issue_read(32'h4000_0000);
    in_araddr = 32'h4000_0100; in_arvalid = 1'b1;
    serve(1'b0, 32'h4000_0000, 32'd0, 4'h0, 0, 1'b0, 32'h8765_4321, 5);
    tick();
    in_arvalid = 1'b0;
    chk("t6_second_setup", out_paddr, 32'h4000_0100);
    tick();
    chk("t6_in_access", 32'(out_penable), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_reset", 32'({out_psel, out_penable, in_rvalid, in_bvalid, in_arready}), 32'd0);
    chk("t6_paddr_zero", out_paddr, 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Randomized transactions checked against the expected APB/AXI outcome.
    for (int t = 0; t < 16; t++) begin
      wr = 1'($urandom_range(0, 1));
      er = ($urandom_range(0, 5) == 0);
      a  = {$urandom_range(0, 255), 2'b00};
      d  = $urandom;
      s  = 4'($urandom_range(1, 15));
      p  = $urandom;
      if (wr) begin
        issue_write(a, d, s, $urandom_range(0, 2));
        serve(1'b1, a, d, s, $urandom_range(0, 3), er, 32'd0, $urandom_range(0, 2));
      end else begin
        issue_read(a);
        serve(1'b0, a, 32'd0, 4'h0, $urandom_range(0, 3), er, p, $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4lite_apb_bridge.md
Name: axi4lite_apb_bridge

Overview:
AXI4-Lite slave to APB3/APB4 master bridge. It sits directly upstream of the APB latency-calibration stage (the delayer) and drives its in_* APB port. One transaction is outstanding at a time. Read/write arbitration is round-robin, and an optional access timeout converts a hung slave into SLVERR.

Parameters:
TIMEOUT, 0, max ACCESS-phase cycles waiting for pready; 0 disables the timeout
PPROT, 3'b000, constant driven on out_pprot

Ports:
clock  input  1  core clock
reset  input  1  reset, asynchronous active-low (asserted at 0)
in_awvalid  input  1  write address valid
in_awready  output  1  write address ready
in_awaddr  input  32  write address
in_wvalid  input  1  write data valid
in_wready  output  1  write data ready
in_wdata  input  32  write data
in_wstrb  input  4  write byte strobes
in_bvalid  output  1  write response valid
in_bready  input  1  write response ready
in_bresp  output  2  2'b00 OKAY, 2'b10 SLVERR
in_arvalid  input  1  read address valid
in_arready  output  1  read address ready
in_araddr  input  32  read address
in_rvalid  output  1  read data valid
in_rready  input  1  read data ready
in_rdata  output  32  read data
in_rresp  output  2  2'b00 OKAY, 2'b10 SLVERR
out_paddr  output  32  APB address
out_psel  output  1  APB select
out_penable  output  1  APB enable
out_pprot  output  3  equals PPROT
out_pwrite  output  1  APB direction
out_pwdata  output  32  APB write data
out_pstrb  output  4  APB strobes; 4'b0000 on reads
out_pready  input  1  APB ready
out_prdata  input  32  APB read data
out_pslverr  input  1  APB error

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0 except out_pprot=PPROT. Holding registers, last-grant flag and timeout counter are cleared.
- Write capture: AW and W are accepted independently, in any order or in the same cycle. awready=!aw_held, wready=!w_held. Each is held only while state==IDLE and no response is pending.
- Read capture: arready=1 only in IDLE, with no write half-captured and no response pending.
- Arbitration in IDLE: a write is eligible when AW and W are both held; a read is eligible when arvalid&arready. If both are eligible the same cycle, grant the type not granted last (after reset, the write wins). A losing AR is not accepted (arready=0 for that cycle).
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
  - SETUP lasts exactly 1 cycle: psel=1, penable=0, and addr/pwrite/pwdata/pstrb are valid and stable until ACCESS exits.
  - ACCESS: psel=1, penable=1. Exit on out_pready, capturing prdata (reads) and pslverr.
  - RESP: bvalid or rvalid held until bready or rready, with rdata/resp stable. On the handshake, go to IDLE.
- Minimum latency: grant cycle N, SETUP N+1, ACCESS N+2 with pready=1, response valid N+3.
- Timeout: when TIMEOUT>0, a counter increments each ACCESS cycle without pready. On reaching TIMEOUT: drop psel/penable, go to RESP with SLVERR, rdata=0.
- In the single cycle where pready and timeout coincide, pready wins.
- rdata is 0 on SLVERR. psel/penable are 0 outside SETUP/ACCESS, and addr/wdata are 0 outside SETUP/ACCESS.
- Reset mid-transaction aborts immediately and drops all valids. No response is emitted.

Decomposition:
- Shared package amba_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, bridge state enum {IDLE,SETUP,ACCESS,RESP}.
- One natural sub-module: axi_wr_capture, the AW/W holding registers with their ready logic.

Test Plan:
1. Write: AW addr=0x1000_0004 at cycle 0, W data=0xDEADBEEF strb=4'hF at cycle 2, pready=1 at first ACCESS. Required: psel at cycle 3, penable at cycle 4, pwdata=0xDEADBEEF, bvalid with bresp=00 at cycle 5.
2. Read with wait states: AR addr=0x1000_0000, slave holds pready=0 for 3 ACCESS cycles then returns 0x12345678. Required: ACCESS held 4 cycles, rdata=0x12345678, rresp=00, pstrb=0.
3. Simultaneous eligible read and write after reset. Required: write is issued first and the read is next; then repeat both together with the read issued first.
4. Error path: pslverr=1 with pready. Required: bresp=2'b10. On a read, rresp=2'b10 and rdata=0.
5. TIMEOUT=8, pready never asserted. Required: 8 ACCESS cycles, psel drops, rresp=2'b10.
6. Backpressure/reset: rready=0 for 5 cycles. Required: rvalid held with rdata stable and no new AR accepted. Then assert reset mid-ACCESS: all valids and psel are 0 asynchronously.
